// File: rtl/alu_shift_addr_unit_pkg.sv
// ============================================================================
// Module   : alu_shift_addr_unit_pkg
// Brief    : Shared encodings for the execute-stage shifter and ALU logic ops.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_shift_addr_unit_pkg;

   localparam logic [2:0] c_sh_lsl = 3'b000;
   localparam logic [2:0] c_sh_lsr = 3'b001;
   localparam logic [2:0] c_sh_asr = 3'b010;
   localparam logic [2:0] c_sh_ror = 3'b011;
   localparam logic [2:0] c_sh_rrx = 3'b100;

   localparam logic [2:0] c_lg_and   = 3'b000;
   localparam logic [2:0] c_lg_or    = 3'b001;
   localparam logic [2:0] c_lg_xor   = 3'b010;
   localparam logic [2:0] c_lg_passb = 3'b011;
   localparam logic [2:0] c_lg_passa = 3'b100;

   localparam logic [31:0] c_addr_step = 32'd4;

endpackage

`default_nettype wire

// File: rtl/alu_shift_addr_unit_barrel_shifter_core.sv
// ============================================================================
// Module   : barrel_shifter_core
// Brief    : Combinational operand-2 barrel shifter with carry-out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module barrel_shifter_core
   import alu_shift_addr_unit_pkg::*;
(
   input  logic [31:0] b,
   input  logic [2:0]  mode,
   input  logic [4:0]  count,
   input  logic        cin,
   output logic [31:0] result,
   output logic        cout
);

   logic [32:0] w_lsl;
   logic [32:0] w_lsr;
   logic [32:0] w_asr;
   logic [31:0] w_ror;

   // Extended forms keep the last bit shifted out as the carry.
   assign w_lsl = {1'b0, b} << count;
   assign w_lsr = {b, 1'b0} >> count;
   assign w_asr = $unsigned($signed({b, 1'b0}) >>> count);
   assign w_ror = 32'({b, b} >> count);

   always_comb begin
      result = b;
      cout   = cin;
      if (mode == c_sh_rrx) begin
         result = {cin, b[31:1]};
         cout   = b[0];
      end else if (count != 5'd0) begin
         case (mode)
            c_sh_lsl: begin result = w_lsl[31:0]; cout = w_lsl[32]; end
            c_sh_lsr: begin result = w_lsr[32:1]; cout = w_lsr[0];  end
            c_sh_asr: begin result = w_asr[32:1]; cout = w_asr[0];  end
            c_sh_ror: begin result = w_ror;       cout = w_ror[31]; end
            default:  begin result = b;           cout = cin;       end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/alu_shift_addr_unit.sv
// ============================================================================
// Module   : alu_shift_addr_unit
// Brief    : Execute slice: barrel shifter, 32-bit ALU with NZCV, address reg.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_shift_addr_unit
   import alu_shift_addr_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] bus_a,
   input  logic [31:0] bus_b,
   input  logic [2:0]  shifter_mode,
   input  logic [4:0]  shifter_count,
   input  logic        shifter_cin,
   output logic [31:0] shifter_output,
   output logic        shifter_cout,
   input  logic        alu_invert_a,
   input  logic        alu_invert_b,
   input  logic        alu_is_logic,
   input  logic [2:0]  alu_logic_idx,
   input  logic        alu_cin,
   input  logic        alu_active,
   output logic [31:0] alu_result,
   output logic        alu_n,
   output logic        alu_z,
   output logic        alu_c,
   output logic        alu_v,
   input  logic        ale,
   input  logic        ainc,
   input  logic        abe,
   output logic [31:0] incrementer_bus,
   output logic [31:0] ar
);

   logic [31:0] w_op_a;
   logic [31:0] w_op_b;
   logic [32:0] w_sum;
   logic [31:0] w_result;
   logic        w_c;
   logic        w_v;

   logic [31:0] r_result;
   logic        r_n;
   logic        r_z;
   logic        r_c;
   logic        r_v;
   logic [31:0] r_addr;

   barrel_shifter_core u_shifter (
      .b      (bus_b),
      .mode   (shifter_mode),
      .count  (shifter_count),
      .cin    (shifter_cin),
      .result (shifter_output),
      .cout   (shifter_cout)
   );

   assign w_op_a = alu_invert_a ? ~bus_a          : bus_a;
   assign w_op_b = alu_invert_b ? ~shifter_output : shifter_output;
   assign w_sum  = {1'b0, w_op_a} + {1'b0, w_op_b} + {32'd0, alu_cin};

   always_comb begin
      w_result = w_sum[31:0];
      w_c      = w_sum[32];
      w_v      = (w_op_a[31] == w_op_b[31]) && (w_sum[31] != w_op_a[31]);
      if (alu_is_logic) begin
         // Logic ops report the shifter carry, as ARM does for MOV/AND/etc.
         w_c = shifter_cout;
         w_v = 1'b0;
         case (alu_logic_idx)
            c_lg_and:   w_result = w_op_a & w_op_b;
            c_lg_or:    w_result = w_op_a | w_op_b;
            c_lg_xor:   w_result = w_op_a ^ w_op_b;
            c_lg_passb: w_result = w_op_b;
            c_lg_passa: w_result = w_op_a;
            default:    w_result = 32'd0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_result <= 32'd0;
         r_n      <= 1'b0;
         r_z      <= 1'b0;
         r_c      <= 1'b0;
         r_v      <= 1'b0;
      end else if (alu_active) begin
         r_result <= w_result;
         r_n      <= w_result[31];
         r_z      <= (w_result == 32'd0);
         r_c      <= w_c;
         r_v      <= w_v;
      end
   end

   // The address latch takes the live ALU result, independent of alu_active.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr <= 32'd0;
      end else if (ale) begin
         r_addr <= w_result;
      end else if (ainc) begin
         r_addr <= incrementer_bus;
      end
   end

   assign incrementer_bus = r_addr + c_addr_step;
   assign ar              = abe ? r_addr : 32'd0;

   assign alu_result = r_result;
   assign alu_n      = r_n;
   assign alu_z      = r_z;
   assign alu_c      = r_c;
   assign alu_v      = r_v;

endmodule

`default_nettype wire

// File: tb/tb_alu_shift_addr_unit.sv
// ============================================================================
// Module   : tb_alu_shift_addr_unit
// Brief    : Self-checking bench: directed cases plus randomized model compare.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_shift_addr_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] bus_a, bus_b;
   logic [2:0]  shifter_mode;
   logic [4:0]  shifter_count;
   logic        shifter_cin;
   logic [31:0] shifter_output;
   logic        shifter_cout;
   logic        alu_invert_a, alu_invert_b, alu_is_logic;
   logic [2:0]  alu_logic_idx;
   logic        alu_cin, alu_active;
   logic [31:0] alu_result;
   logic        alu_n, alu_z, alu_c, alu_v;
   logic        ale, ainc, abe;
   logic [31:0] incrementer_bus, ar;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   alu_shift_addr_unit dut (
      .clk(clk), .rst(rst), .bus_a(bus_a), .bus_b(bus_b),
      .shifter_mode(shifter_mode), .shifter_count(shifter_count),
      .shifter_cin(shifter_cin), .shifter_output(shifter_output),
      .shifter_cout(shifter_cout), .alu_invert_a(alu_invert_a),
      .alu_invert_b(alu_invert_b), .alu_is_logic(alu_is_logic),
      .alu_logic_idx(alu_logic_idx), .alu_cin(alu_cin),
      .alu_active(alu_active), .alu_result(alu_result),
      .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
      .ale(ale), .ainc(ainc), .abe(abe),
      .incrementer_bus(incrementer_bus), .ar(ar)
   );

   // Reference shifter: {carry, output}, built from one-bit steps and arithmetic.
   function automatic logic [32:0] ref_shift(input logic [2:0] m, input int n,
                                             input logic [31:0] b, input logic cin);
      logic [31:0] o;
      logic        c;
      logic [63:0] w;
      o = b;
      c = cin;
      if (m == 3'd4) begin
         o = {cin, b[31:1]};
         c = b[0];
      end else if (n != 0 && m <= 3'd3) begin
         case (m)
            3'd0: begin w = {32'd0, b} << n; o = w[31:0]; c = w[32]; end
            3'd1: begin o = b / (32'd1 << n); c = b[n-1]; end
            3'd2: for (int i = 0; i < n; i++) begin c = o[0]; o = {o[31], o[31:1]}; end
            default: for (int i = 0; i < n; i++) begin c = o[0]; o = {o[0], o[31:1]}; end
         endcase
      end
      return {c, o};
   endfunction

   // Reference ALU: {N, Z, C, V, result}; V from true signed range overflow.
   function automatic logic [35:0] ref_alu(input logic [31:0] a, input logic [31:0] sb,
                                           input logic scout, input logic ia, input logic ib,
                                           input logic il, input logic [2:0] li, input logic ci);
      logic [31:0] a2, b2, r;
      logic [63:0] s;
      longint      ss;
      logic        c, v;
      a2 = ia ? ~a : a;
      b2 = ib ? ~sb : sb;
      if (il) begin
         case (li)
            3'd0: r = a2 & b2;
            3'd1: r = a2 | b2;
            3'd2: r = a2 ^ b2;
            3'd3: r = b2;
            3'd4: r = a2;
            default: r = 32'd0;
         endcase
         c = scout;
         v = 1'b0;
      end else begin
         s  = {32'd0, a2} + {32'd0, b2} + {63'd0, ci};
         r  = s[31:0];
         c  = s[32];
         ss = longint'($signed(a2)) + longint'($signed(b2)) + longint'(ci);
         v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      return {r[31], (r == 32'd0), c, v, r};
   endfunction

   task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m,
                        input logic [4:0] n, input logic sc, input logic ia, input logic ib,
                        input logic il, input logic [2:0] li, input logic ci, input logic act);
      bus_a = a; bus_b = b; shifter_mode = m; shifter_count = n; shifter_cin = sc;
      alu_invert_a = ia; alu_invert_b = ib; alu_is_logic = il; alu_logic_idx = li;
      alu_cin = ci; alu_active = act;
   endtask

   task automatic test_reset();
      rst = 1'b1; ale = 1'b1; ainc = 1'b1; abe = 1'b1;
      drive(32'h1234_5678, 32'h0000_00FF, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0; ale = 1'b0; ainc = 1'b0; alu_active = 1'b0;
      #1;
      n_total++;
      if (ar !== 32'd0) $display("FAIL reset_ar: got %h want %h", ar, 32'd0);
      else n_pass++;
      n_total++;
      if (incrementer_bus !== 32'd4) $display("FAIL reset_inc: got %h want %h", incrementer_bus, 32'd4);
      else n_pass++;
      n_total++;
      if (alu_result !== 32'd0) $display("FAIL reset_result: got %h want %h", alu_result, 32'd0);
      else n_pass++;
      n_total++;
      if ({alu_n, alu_z, alu_c, alu_v} !== 4'b0000)
         $display("FAIL reset_nzcv: got %b want 0000", {alu_n, alu_z, alu_c, alu_v});
      else n_pass++;
   endtask

   task automatic test_add_sub();
      logic [31:0] va [4] = '{32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'h7FFF_FFFF, 32'h0000_000F};
      logic [31:0] vb [4] = '{32'h0000_000F, 32'h0000_0010, 32'h0000_0001, 32'h0000_000F};
      logic        vib[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic [31:0] er [4] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000};
      logic [3:0]  ef [4] = '{4'b1000, 4'b0110, 4'b1001, 4'b0110};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive(va[i], vb[i], 3'd0, 5'd0, 1'b0, 1'b0, vib[i], 1'b0, 3'd0, vib[i], 1'b1);
         @(posedge clk);
         #1;
         alu_active = 1'b0;
         n_total++;
         if (alu_result !== er[i]) $display("FAIL add_result[%0d]: got %h want %h", i, alu_result, er[i]);
         else n_pass++;
         n_total++;
         if ({alu_n, alu_z, alu_c, alu_v} !== ef[i])
            $display("FAIL add_nzcv[%0d]: got %b want %b", i, {alu_n, alu_z, alu_c, alu_v}, ef[i]);
         else n_pass++;
      end
   endtask

   task automatic test_shifter();
      logic [2:0]  vm [4] = '{3'd0, 3'd2, 3'd3, 3'd4};
      logic [4:0]  vn [4] = '{5'd4, 5'd4, 5'd8, 5'd0};
      logic [31:0] vb [4] = '{32'h0000_000F, 32'h8000_0000, 32'h0000_00FF, 32'h0000_0001};
      logic        vc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic [31:0] eo [4] = '{32'h0000_00F0, 32'hF800_0000, 32'hFF00_0000, 32'h8000_0000};
      logic        ec [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive(32'd0, vb[i], vm[i], vn[i], vc[i], 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
         #1;
         n_total++;
         if (shifter_output !== eo[i] || shifter_cout !== ec[i])
            $display("FAIL shift_dir[%0d]: got %h/%b want %h/%b", i, shifter_output, shifter_cout, eo[i], ec[i]);
         else n_pass++;
      end
   endtask

   task automatic test_random_alu();
      logic [32:0] es;
      logic [35:0] ea;
      logic [31:0] held;
      logic [31:0] corner [4] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
      for (int i = 0; i < 60; i++) begin
         logic [31:0] a, b;
         a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
         b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
         @(negedge clk);
         drive(a, b, 3'($urandom_range(0, 7)), 5'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)), 1'($urandom), 1'b1);
         #1;
         es = ref_shift(shifter_mode, int'(shifter_count), bus_b, shifter_cin);
         ea = ref_alu(bus_a, es[31:0], es[32], alu_invert_a, alu_invert_b,
                      alu_is_logic, alu_logic_idx, alu_cin);
         n_total++;
         if ({shifter_cout, shifter_output} !== es)
            $display("FAIL rand_shift[%0d]: got %b/%h want %b/%h mode %0d n %0d",
                     i, shifter_cout, shifter_output, es[32], es[31:0], shifter_mode, shifter_count);
         else n_pass++;
         @(posedge clk);
         #1;
         n_total++;
         if ({alu_n, alu_z, alu_c, alu_v, alu_result} !== ea)
            $display("FAIL rand_alu[%0d]: got %b %h want %b %h", i,
                     {alu_n, alu_z, alu_c, alu_v}, alu_result, ea[35:32], ea[31:0]);
         else n_pass++;
      end
      // Inactive cycles must hold the last captured result.
      held = ea[31:0];
      @(negedge clk);
      drive(~held, 32'h1, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      n_total++;
      if ({alu_n, alu_z, alu_c, alu_v, alu_result} !== ea)
         $display("FAIL alu_hold: got %b %h want %b %h", {alu_n, alu_z, alu_c, alu_v},
                  alu_result, ea[35:32], ea[31:0]);
      else n_pass++;
   endtask

   task automatic test_addr();
      @(negedge clk);
      abe = 1'b1; ale = 1'b1; ainc = 1'b0;
      drive(32'h0000_0100, 32'd0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      n_total++;
      if (ar !== 32'h100 || incrementer_bus !== 32'h104)
         $display("FAIL addr_load: got %h/%h want 00000100/00000104", ar, incrementer_bus);
      else n_pass++;
      @(negedge clk);
      ale = 1'b0; ainc = 1'b1;
      @(posedge clk);
      #1;
      n_total++;
      if (ar !== 32'h104) $display("FAIL addr_inc: got %h want %h", ar, 32'h104);
      else n_pass++;
      @(negedge clk);
      ainc = 1'b0; abe = 1'b0;
      #1;
      n_total++;
      if (ar !== 32'd0 || incrementer_bus !== 32'h108)
         $display("FAIL addr_abe_off: got %h/%h want 00000000/00000108", ar, incrementer_bus);
      else n_pass++;
      @(negedge clk);
      abe = 1'b1; ale = 1'b1; ainc = 1'b1;
      drive(32'hFFFF_FFF0, 32'h0000_000C, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      n_total++;
      if (ar !== 32'hFFFF_FFFC || incrementer_bus !== 32'h0)
         $display("FAIL addr_ale_prio_wrap: got %h/%h want fffffffc/00000000", ar, incrementer_bus);
      else n_pass++;
      @(negedge clk);
      ale = 1'b0; ainc = 1'b1;
      @(posedge clk);
      #1;
      n_total++;
      if (ar !== 32'h0) $display("FAIL addr_inc_wrap: got %h want %h", ar, 32'h0);
      else n_pass++;
      @(negedge clk);
      ainc = 1'b0;
      drive(32'hDEAD_BEEF, 32'd0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      alu_active = 1'b0;
      n_total++;
      if (ar !== 32'h0) $display("FAIL addr_hold: got %h want %h", ar, 32'h0);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_shifter();
      test_random_alu();
      test_addr();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
